// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared types, error codes and helpers for the UART word loader
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_LEN_L,
        ST_LEN_H,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_SEL     = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/upg_timeout_ctr.sv
// rtl/upg_timeout_ctr.sv - inter-byte idle counter that expires after TIMEOUT_CYC quiet cycles
module upg_timeout_ctr
    import uart_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = clog2_min1(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt;

    // A byte in the same cycle as the terminal count suppresses expiry.
    assign expire = enable && !clear && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (!expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// rtl/uart_word_loader.sv - parses framed UART downloads into 32-bit memory writes
module uart_word_loader
    import uart_loader_pkg::*;
#(
    parameter int         ADDR_W      = 14,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEFAULT
) (
    input  logic              upg_clk_i,
    input  logic              upg_rstn_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              upg_wen_o,
    output logic [ADDR_W:0]   upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              busy_o,
    output logic [2:0]        err_o
);

    localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_W;

    state_t            state, next_state;
    logic              target;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [1:0]        byte_cnt;
    logic [23:0]       word;
    logic [ADDR_W-1:0] word_idx;
    logic [7:0]        csum;
    logic              busy, expire, last_word;
    logic              start_frame, write_word, set_done;
    logic [2:0]        err_code;

    assign busy      = !(state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign busy_o    = busy;
    assign last_word = (32'(word_idx) + 32'd1) == {16'd0, len};

    upg_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk    (upg_clk_i),
        .rst_n  (upg_rstn_i),
        .clear  (rx_valid_i),
        .enable (busy),
        .expire (expire)
    );

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) state <= ST_IDLE;
        else             state <= next_state;
    end

    always_comb begin
        next_state  = state;
        err_code    = ERR_NONE;
        start_frame = 1'b0;
        write_word  = 1'b0;
        set_done    = 1'b0;
        if (expire) begin
            next_state = ST_ERR;
            err_code   = ERR_TIMEOUT;
        end else if (rx_valid_i) begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (rx_data_i == HDR_BYTE) begin
                        next_state  = ST_SEL;
                        start_frame = 1'b1;
                    end
                end
                ST_SEL: begin
                    if (rx_data_i[7:1] == 7'd0) begin
                        next_state = ST_LEN_L;
                    end else begin
                        next_state = ST_ERR;
                        err_code   = ERR_SEL;
                    end
                end
                ST_LEN_L: next_state = ST_LEN_H;
                ST_LEN_H: begin
                    if ({16'd0, rx_data_i, len_lo} > MAX_LEN) begin
                        next_state = ST_ERR;
                        err_code   = ERR_LEN;
                    end else if ({rx_data_i, len_lo} == 16'd0) begin
                        next_state = ST_CSUM;
                    end else begin
                        next_state = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_cnt == 2'd3) begin
                        write_word = 1'b1;
                        if (last_word) next_state = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (rx_data_i == csum) begin
                        next_state = ST_DONE;
                        set_done   = 1'b1;
                    end else begin
                        next_state = ST_ERR;
                        err_code   = ERR_CSUM;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_done_o <= 1'b0;
            err_o      <= ERR_NONE;
            target     <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            byte_cnt   <= '0;
            word       <= '0;
            word_idx   <= '0;
            csum       <= '0;
        end else begin
            upg_wen_o <= write_word;
            if (start_frame) begin
                upg_done_o <= 1'b0;
                err_o      <= ERR_NONE;
                word_idx   <= '0;
                csum       <= '0;
                byte_cnt   <= '0;
            end
            if (err_code != ERR_NONE) err_o <= err_code;
            if (set_done) upg_done_o <= 1'b1;
            if (rx_valid_i && state == ST_SEL)   target <= rx_data_i[0];
            if (rx_valid_i && state == ST_LEN_L) len_lo <= rx_data_i;
            if (rx_valid_i && state == ST_LEN_H) len    <= {rx_data_i, len_lo};
            if (rx_valid_i && state == ST_DATA) begin
                csum     <= csum ^ rx_data_i;
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    word[7:0]   <= rx_data_i;
                    2'd1:    word[15:8]  <= rx_data_i;
                    2'd2:    word[23:16] <= rx_data_i;
                    default: ;
                endcase
            end
            // Lane 3 goes straight to the output, so the write lands one cycle after it.
            if (write_word) begin
                upg_adr_o <= {target, word_idx};
                upg_dat_o <= {rx_data_i, word};
                word_idx  <= word_idx + 1'b1;
            end
        end
    end

endmodule
